// File: rtl/gps_sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : gps_sample_fifo
//  Purpose  : Captures the 2-bit I/Q front-end nibble on every rising edge of
//             the asynchronous GPS sample clock and drains it on a fixed
//             4-clock slot grid. Each drained nibble is strobed with a
//             one-cycle DATAREADY and held for the whole slot.
//
//  Ports    :
//     MCU_CLK_25_000   in   system clock, all logic on its rising edge
//     RESET_N          in   asynchronous active-low reset
//     GPS_CLK          in   front-end sample clock (asynchronous)
//     GPS_I0_IN..Q1_IN in   raw sample bits
//     TX_EN            in   drain enable, sampled only in slot 0
//     GPS_I0..GPS_Q1   out  held sample to the bridge
//     DATAREADY        out  one-cycle strobe, new sample this cycle
//     FIFO_LEVEL       out  occupancy 0..2**FIFO_AW
//     OVERFLOW         out  sticky, a sample was dropped
//     DROP_COUNT       out  saturating dropped-sample count (optional)
//
//  Config   : define GPS_FIFO_DROPCNT_EN to add the DROP_COUNT[7:0] output.
//
//  Revision : 1.0  initial release
// ============================================================================
module gps_sample_fifo #(
   parameter int FIFO_AW = 4
) (
   input  logic               MCU_CLK_25_000,
   input  logic               RESET_N,
   input  logic               GPS_CLK,
   input  logic               GPS_I0_IN,
   input  logic               GPS_I1_IN,
   input  logic               GPS_Q0_IN,
   input  logic               GPS_Q1_IN,
   input  logic               TX_EN,
   output logic               GPS_I0,
   output logic               GPS_I1,
   output logic               GPS_Q0,
   output logic               GPS_Q1,
   output logic               DATAREADY,
   output logic [FIFO_AW:0]   FIFO_LEVEL,
   output logic               OVERFLOW
`ifdef GPS_FIFO_DROPCNT_EN
   ,
   output logic [7:0]         DROP_COUNT
`endif
);

   localparam int                 DEPTH_N = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0]   DEPTH   = {1'b1, {FIFO_AW{1'b0}}};

   // Synchroniser and data alignment pipeline
   logic             s0_q, s1_q, s2_q;
   logic             s0_d, s1_d, s2_d;
   logic [3:0]       d0_q, d1_q;
   logic [3:0]       d0_d, d1_d;

   // Arm counter: edge detection held off for the first clocks after reset
   logic [1:0]       arm_q, arm_d;

   // FIFO state
   logic [3:0]       mem_q [DEPTH_N];
   logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;

   // Drain side
   logic [1:0]       slot_q, slot_d;
   logic [3:0]       out_q, out_d;
   logic             dataready_q, dataready_d;
   logic             overflow_q, overflow_d;

   logic [FIFO_AW:0] level;
   logic             full;
   logic             gps_edge;
   logic             pop;
   logic             push;
   logic             drop;

   // Occupancy from free-running pointers; the extra MSB separates full from empty
   assign level    = wr_ptr_q - rd_ptr_q;
   assign full     = (level == DEPTH);
   assign gps_edge = s1_q & ~s2_q & (arm_q == 2'd3);
   assign pop      = (slot_q == 2'd0) & TX_EN & (level != '0);
   // A full FIFO still accepts a sample when a pop frees a slot the same cycle
   assign push     = gps_edge & (~full | pop);
   assign drop     = gps_edge & full & ~pop;

   always_comb begin
      s0_d        = GPS_CLK;
      s1_d        = s0_q;
      s2_d        = s1_q;
      d0_d        = {GPS_Q1_IN, GPS_Q0_IN, GPS_I1_IN, GPS_I0_IN};
      d1_d        = d0_q;
      arm_d       = (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;
      wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      // Slot runs 1->2->3->0 once started; it only leaves 0 on a pop
      if (slot_q != 2'd0) begin
         slot_d = slot_q + 2'd1;
      end else begin
         slot_d = pop ? 2'd1 : 2'd0;
      end
      // Read happens before the same-edge write, so a full+pop+push cycle
      // returns the oldest entry even though the write targets that location
      out_d       = pop ? mem_q[rd_ptr_q[FIFO_AW-1:0]] : out_q;
      dataready_d = pop;
      overflow_d  = overflow_q | drop;
   end

   always_ff @(posedge MCU_CLK_25_000 or negedge RESET_N) begin
      if (!RESET_N) begin
         s0_q        <= 1'b0;
         s1_q        <= 1'b0;
         s2_q        <= 1'b0;
         d0_q        <= 4'd0;
         d1_q        <= 4'd0;
         arm_q       <= 2'd0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         slot_q      <= 2'd0;
         out_q       <= 4'd0;
         dataready_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         s0_q        <= s0_d;
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         d0_q        <= d0_d;
         d1_q        <= d1_d;
         arm_q       <= arm_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         slot_q      <= slot_d;
         out_q       <= out_d;
         dataready_q <= dataready_d;
         overflow_q  <= overflow_d;
      end
   end

   // Storage array carries no reset; pointers define what is valid
   always_ff @(posedge MCU_CLK_25_000) begin
      if (push) begin
         mem_q[wr_ptr_q[FIFO_AW-1:0]] <= d1_q;
      end
   end

`ifdef GPS_FIFO_DROPCNT_EN
   logic [7:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != 8'hFF)) begin
         drop_cnt_d = drop_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge MCU_CLK_25_000 or negedge RESET_N) begin
      if (!RESET_N) begin
         drop_cnt_q <= 8'd0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign DROP_COUNT = drop_cnt_q;
`else
`endif

   assign {GPS_Q1, GPS_Q0, GPS_I1, GPS_I0} = out_q;
   assign DATAREADY  = dataready_q;
   assign FIFO_LEVEL = level;
   assign OVERFLOW   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_gps_sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gps_sample_fifo
//  Purpose  : Self-checking bench for gps_sample_fifo. Stimulus pushes each
//             nibble the FIFO should deliver into an expected queue; a monitor
//             pops it on every DATAREADY and also checks output hold and
//             strobe spacing.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gps_sample_fifo;

   logic       clk    = 1'b0;
   logic       rst_n  = 1'b1;
   logic       gps_clk = 1'b0;
   logic [3:0] din    = 4'd0;
   logic       tx_en  = 1'b1;
   logic       i0, i1, q0, q1;
   logic       dataready;
   logic [4:0] level;
   logic       overflow;
`ifdef GPS_FIFO_DROPCNT_EN
   logic [7:0] drop_count;
`endif
   logic [3:0] dout;

   int         n_cmp = 0;
   int         n_err = 0;
   int         cyc   = 0;
   logic [3:0] exp_q[$];
   int         strobe_cyc[$];
   logic [3:0] last_val    = 4'd0;
   int         last_strobe = -1000;

   assign dout = {q1, q0, i1, i0};

   gps_sample_fifo #(.FIFO_AW(4)) dut (
      .MCU_CLK_25_000 (clk),
      .RESET_N        (rst_n),
      .GPS_CLK        (gps_clk),
      .GPS_I0_IN      (din[0]),
      .GPS_I1_IN      (din[1]),
      .GPS_Q0_IN      (din[2]),
      .GPS_Q1_IN      (din[3]),
      .TX_EN          (tx_en),
      .GPS_I0         (i0),
      .GPS_I1         (i1),
      .GPS_Q0         (q0),
      .GPS_Q1         (q1),
      .DATAREADY      (dataready),
      .FIFO_LEVEL     (level),
      .OVERFLOW       (overflow)
`ifdef GPS_FIFO_DROPCNT_EN
      ,
      .DROP_COUNT     (drop_count)
`endif
   );

   always #20 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: output checking decoupled from stimulus
   always @(posedge clk) begin
      #1;
      if (!rst_n) begin
         last_val    = 4'd0;
         last_strobe = -1000;
      end else if (dataready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_strobe: got %0h with nothing outstanding (cycle %0d)", dout, cyc);
         end else begin
            chk("strobe_data", dout, exp_q.pop_front());
         end
         chk("min_spacing", (cyc - last_strobe) >= 4, 1);
         strobe_cyc.push_back(cyc);
         last_val    = dout;
         last_strobe = cyc;
      end else begin
         chk("hold", dout, last_val);
      end
   end

   // One GPS sample: low phase with new data, then rising edge and high phase.
   // Called and returns at a falling clock edge.
   task automatic sample(input logic [3:0] nib, input int lo, input int hi, input bit expect_it);
      din     = nib;
      gps_clk = 1'b0;
      repeat (lo) @(negedge clk);
      gps_clk = 1'b1;
      if (expect_it) exp_q.push_back(nib);
      repeat (hi) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n   = 1'b0;
      gps_clk = 1'b0;
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 400) begin
         @(negedge clk);
         t++;
      end
      repeat (6) @(negedge clk);
      chk("drain_timeout", exp_q.size(), 0);
   endtask

   initial begin
      int base;
      int dropped_strobes;

      // Reset held while GPS_CLK toggles; released with GPS_CLK high
      #2 rst_n = 1'b0;
      repeat (5) begin
         repeat (2) @(negedge clk);
         gps_clk = ~gps_clk;
         chk("rst_dataready", dataready, 0);
         chk("rst_dout", dout, 0);
         chk("rst_level", level, 0);
         chk("rst_overflow", overflow, 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) begin
         @(negedge clk);
         chk("arm_level", level, 0);
         chk("arm_dataready", dataready, 0);
      end
      gps_clk = 1'b0;
      repeat (3) @(negedge clk);

      // Single rise, latency check: I0=0 I1=1 Q0=0 Q1=1
      din = 4'b1010;
      repeat (2) @(negedge clk);
      gps_clk = 1'b1;
      exp_q.push_back(4'b1010);
      @(posedge clk);          // edge k
      @(posedge clk);          // k+1
      @(posedge clk);          // k+2: write
      #2;
      chk("lat_level_k2", level, 1);
      chk("lat_dr_k2", dataready, 0);
      @(posedge clk);          // k+3: pop
      #2;
      chk("lat_dr_k3", dataready, 1);
      chk("lat_dout_k3", dout, 4'b1010);
      chk("lat_level_k3", level, 0);
      @(posedge clk);
      #2;
      chk("lat_dr_k4", dataready, 0);
      @(negedge clk);
      gps_clk = 1'b0;
      repeat (8) @(negedge clk);
      chk("lat_held", dout, 4'b1010);

      // 100 samples at period 4: one strobe each, exactly 4 apart
      base = strobe_cyc.size();
      for (int i = 0; i < 100; i++) sample(4'(i), 2, 2, 1'b1);
      drain();
      chk("burst_count", strobe_cyc.size() - base, 100);
      for (int j = base + 1; j < strobe_cyc.size(); j++)
         chk("burst_spacing", strobe_cyc[j] - strobe_cyc[j-1], 4);
      chk("burst_overflow", overflow, 0);

      // Fill to exactly 16, then a push coincident with the first pop
      do_reset();
      tx_en = 1'b0;
      for (int i = 0; i < 16; i++) sample(4'(i) ^ 4'h5, 2, 2, 1'b1);
      din     = 4'hC;
      gps_clk = 1'b0;
      repeat (2) @(negedge clk);
      gps_clk = 1'b1;
      exp_q.push_back(4'hC);
      @(negedge clk);          // after k
      @(negedge clk);          // after k+1
      chk("full_level", level, 16);
      chk("full_overflow", overflow, 0);
      tx_en = 1'b1;            // pop at k+2, coincident with the write
      @(negedge clk);
      chk("coinc_level", level, 16);
      chk("coinc_overflow", overflow, 0);
`ifdef GPS_FIFO_DROPCNT_EN
      chk("coinc_dropcnt", drop_count, 0);
`endif
      drain();
      chk("coinc_drained_level", level, 0);

      // 20 edges with drain disabled: last 4 dropped
      do_reset();
      tx_en = 1'b0;
      for (int i = 0; i < 20; i++) sample(4'($urandom_range(0, 15)), 2, 2, i < 16);
      repeat (2) @(negedge clk);
      chk("ovf_level", level, 16);
      chk("ovf_flag", overflow, 1);
`ifdef GPS_FIFO_DROPCNT_EN
      chk("ovf_dropcnt", drop_count, 4);
`endif
      gps_clk = 1'b0;
      tx_en   = 1'b1;
      drain();
      chk("ovf_drained_level", level, 0);
      chk("ovf_sticky", overflow, 1);

      // Reset asserted on the second cycle of a slot with level 5
      do_reset();
      chk("post_reset_overflow", overflow, 0);
      tx_en = 1'b0;
      for (int i = 0; i < 6; i++) sample(4'(i + 3), 2, 2, 1'b1);
      gps_clk = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_level6", level, 6);
      tx_en = 1'b1;
      @(negedge clk);          // pop taken, slot cycle 1
      chk("mid_level5", level, 5);
      chk("mid_dr", dataready, 1);
      @(negedge clk);          // slot cycle 2
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("mid_rst_dr", dataready, 0);
      chk("mid_rst_dout", dout, 0);
      chk("mid_rst_level", level, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      dropped_strobes = strobe_cyc.size();
      repeat (20) @(negedge clk);
      chk("mid_no_strobe", strobe_cyc.size() - dropped_strobes, 0);
      chk("mid_idle_level", level, 0);
      for (int i = 0; i < 3; i++) sample(4'(9 - i), 2, 2, 1'b1);
      drain();

      // Randomized rates at or below one sample per 4 clocks
      for (int i = 0; i < 60; i++)
         sample(4'($urandom_range(0, 15)), $urandom_range(2, 4), $urandom_range(2, 4), 1'b1);
      gps_clk = 1'b0;
      drain();
      chk("rand_overflow", overflow, 0);
      chk("rand_level", level, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
